// File: rtl/paddle_ctrl.sv
`default_nettype none
// ============================================================================
// paddle_ctrl : push-button paddle position with hold-to-auto-repeat
// Rev 1.0
// ============================================================================
module paddle_ctrl #(
  parameter int CLK_PER_MS = 100000,
  parameter int HOLD_MS    = 300,
  parameter int REPEAT_MS  = 50,
  parameter int STEP       = 8,
  parameter int Y_MAX      = 400,
  parameter int Y_INIT     = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [9:0] paddle_y,
  output logic       move_pulse,
  output logic       move_dir
);

  localparam int PW     = $clog2(CLK_PER_MS);
  localparam int MS_MAX = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
  localparam int MW     = $clog2(MS_MAX + 1);

  localparam logic [PW-1:0] C_PRESC_LAST = PW'(CLK_PER_MS - 1);
  localparam logic [MW-1:0] C_HOLD_LAST  = MW'(HOLD_MS - 1);
  localparam logic [MW-1:0] C_REP_LAST   = MW'(REPEAT_MS - 1);
  localparam logic [9:0]    C_STEP       = 10'(STEP);
  localparam logic [10:0]   C_STEP_W     = 11'(STEP);
  localparam logic [10:0]   C_YMAX_W     = 11'(Y_MAX);
  localparam logic [9:0]    C_YMAX       = 10'(Y_MAX);
  localparam logic [9:0]    C_YINIT      = 10'(Y_INIT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_up_s1, r_up_s2, r_dn_s1, r_dn_s2;
  logic [PW-1:0] r_presc;
  logic [MW-1:0] r_ms;
  logic          r_dir;

  logic          w_tick, w_up_req, w_dn_req, w_match, w_step_dir;
  logic          w_do_step, w_step_moves;
  logic [9:0]    w_y_up, w_y_dn, w_step_y;
  logic [10:0]   w_y_sum;

  always_comb begin
    w_up_req   = r_up_s2 & ~r_dn_s2;
    w_dn_req   = r_dn_s2 & ~r_up_s2;
    w_tick     = (r_presc == C_PRESC_LAST);
    w_match    = r_dir ? w_dn_req : w_up_req;
    // In IDLE the direction comes from the live request, otherwise from the latched one
    w_step_dir = (r_state == ST_IDLE) ? w_dn_req : r_dir;

    w_y_up   = (paddle_y < C_STEP) ? 10'd0 : (paddle_y - C_STEP);
    w_y_sum  = {1'b0, paddle_y} + C_STEP_W;
    w_y_dn   = (w_y_sum > C_YMAX_W) ? C_YMAX : w_y_sum[9:0];
    w_step_y = w_step_dir ? w_y_dn : w_y_up;
    w_step_moves = (w_step_y != paddle_y);

    w_do_step = 1'b0;
    case (r_state)
      ST_IDLE:   w_do_step = w_up_req | w_dn_req;
      ST_HOLD:   w_do_step = w_match & w_tick & (r_ms == C_HOLD_LAST);
      ST_REPEAT: w_do_step = w_match & w_tick & (r_ms == C_REP_LAST);
      default:   w_do_step = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_up_s1    <= 1'b0;
      r_up_s2    <= 1'b0;
      r_dn_s1    <= 1'b0;
      r_dn_s2    <= 1'b0;
      r_presc    <= '0;
      r_ms       <= '0;
      r_dir      <= 1'b0;
      r_state    <= ST_IDLE;
      paddle_y   <= C_YINIT;
      move_pulse <= 1'b0;
      move_dir   <= 1'b0;
    end else begin
      r_up_s1    <= btn_up;
      r_up_s2    <= r_up_s1;
      r_dn_s1    <= btn_down;
      r_dn_s2    <= r_dn_s1;
      r_presc    <= w_tick ? '0 : r_presc + 1'b1;
      move_pulse <= 1'b0;

      // A step clamped to its current value is silent but keeps the FSM schedule
      if (w_do_step && w_step_moves) begin
        paddle_y   <= w_step_y;
        move_pulse <= 1'b1;
        move_dir   <= w_step_dir;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_up_req || w_dn_req) begin
            r_dir   <= w_dn_req;
            r_ms    <= '0;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!w_match) begin
            r_state <= ST_IDLE;
          end else if (w_tick) begin
            if (r_ms == C_HOLD_LAST) begin
              r_ms    <= '0;
              r_state <= ST_REPEAT;
            end else begin
              r_ms <= r_ms + 1'b1;
            end
          end
        end
        ST_REPEAT: begin
          if (!w_match) begin
            r_state <= ST_IDLE;
          end else if (w_tick) begin
            r_ms <= (r_ms == C_REP_LAST) ? '0 : r_ms + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
